// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V load/store size and sign encodings (Funct3).
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/data_mem.sv
// data_mem: word-organised data array with byte-enable writes and a combinational read port.
module data_mem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  // Contents are intentionally never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/memory_cc.sv
// memory_cc: M stage data access with load extension, misalign detection and the MEM/WB register.
module memory_cc
  import riscv_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RDW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW,
  output logic        MisalignW
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] rdata, wdata, ext, read_d;
  logic [15:0] rh;
  logic [7:0]  rb;
  logic [3:0]  be;
  logic        valid, mis, we;
  logic        regwrite_q, resultsrc_q, mis_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q, read_q;
  assign rb = rdata[{ALUResultM[1:0], 3'b000} +: 8];
  assign rh = ALUResultM[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    be    = 4'b0000;
    wdata = WriteDataM;
    ext   = '0;
    valid = 1'b1;
    case (Funct3M)
      F3_B, F3_BU: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
        ext   = Funct3M[2] ? {24'b0, rb} : {{24{rb[7]}}, rb};
      end
      F3_H, F3_HU: begin
        be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
        ext   = Funct3M[2] ? {16'b0, rh} : {{16{rh[15]}}, rh};
      end
      F3_W: begin
        be  = 4'b1111;
        ext = rdata;
      end
      default: valid = 1'b0;
    endcase
  end
  assign mis = ((Funct3M == F3_H || Funct3M == F3_HU) && ALUResultM[0]) ||
               (Funct3M == F3_W && ALUResultM[1:0] != 2'b00);
  // Gating with rst drops a store whose edge falls while reset is held.
  assign we     = MemWriteM && valid && !mis && rst;
  assign read_d = (valid && !mis) ? ext : '0;
  data_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (we),
    .be_i   (be),
    .addr_i (ALUResultM[AW+1:2]),
    .wdata_i(wdata),
    .rdata_o(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      mis_q       <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      read_q      <= '0;
    end else begin
      regwrite_q  <= RegWriteM;
      resultsrc_q <= ResultSrcM;
      mis_q       <= mis;
      rd_q        <= RDM;
      alu_q       <= ALUResultM;
      read_q      <= read_d;
    end
  end
  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign MisalignW  = mis_q;
  assign RDW        = rd_q;
  assign ALUResultW = alu_q;
  assign ReadDataW  = read_q;
  assign ResultW    = resultsrc_q ? read_q : alu_q;
endmodule

// File: tb/tb_memory_cc.sv
// tb_memory_cc: directed checks of memory_cc loads, stores, misalignment, wrap and reset.
module tb_memory_cc;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]  RDW;
  logic [31:0] ALUResultW, ReadDataW, ResultW;
  int total = 0;
  int bad = 0;

  memory_cc #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .ResultW(ResultW),
    .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic rs, input logic mw, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    RDM = rd; ALUResultM = a; WriteDataM = wd;
  endtask

  task automatic step(input logic rw, input logic rs, input logic mw, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd);
    drive(rw, rs, mw, f3, rd, a, wd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0010, 32'h1234_5678);
    @(posedge clk);
    #1;
    chk("rst_regwrite", {31'b0, RegWriteW}, 32'd0);
    chk("rst_resultsrc", {31'b0, ResultSrcW}, 32'd0);
    chk("rst_rd", {27'b0, RDW}, 32'd0);
    chk("rst_alu", ALUResultW, 32'd0);
    chk("rst_read", ReadDataW, 32'd0);
    chk("rst_result", ResultW, 32'd0);
    chk("rst_mis", {31'b0, MisalignW}, 32'd0);
    rst = 1'b1;

    step(1'b0, 1'b0, 1'b1, 3'b010, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("sw_mis", {31'b0, MisalignW}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h0000_0010, 32'h0);
    chk("lw_10", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_10_result", ResultW, 32'hDEAD_BEEF);
    chk("lw_10_rd", {27'b0, RDW}, 32'd3);

    step(1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h0000_0013, 32'h0000_0080);
    step(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'h0000_0013, 32'h0);
    chk("lb_13", ReadDataW, 32'hFFFF_FF80);
    step(1'b1, 1'b1, 1'b0, 3'b100, 5'd4, 32'h0000_0013, 32'h0);
    chk("lbu_13", ReadDataW, 32'h0000_0080);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0010, 32'h0);
    chk("lw_10_after_sb", ReadDataW, 32'h80AD_BEEF);
    step(1'b1, 1'b1, 1'b0, 3'b001, 5'd4, 32'h0000_0012, 32'h0);
    chk("lh_12", ReadDataW, 32'hFFFF_80AD);
    step(1'b1, 1'b1, 1'b0, 3'b101, 5'd4, 32'h0000_0010, 32'h0);
    chk("lhu_10", ReadDataW, 32'h0000_BEEF);
    step(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'h0000_0011, 32'h0);
    chk("lb_11", ReadDataW, 32'hFFFF_FFBE);

    step(1'b0, 1'b0, 1'b1, 3'b010, 5'd0, 32'h0000_0020, 32'hCAFE_F00D);
    step(1'b0, 1'b0, 1'b1, 3'b001, 5'd0, 32'h0000_0021, 32'h0000_1234);
    chk("sh_21_mis", {31'b0, MisalignW}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0020, 32'h0);
    chk("lw_20_unchanged", ReadDataW, 32'hCAFE_F00D);
    chk("lw_20_mis", {31'b0, MisalignW}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0022, 32'h0);
    chk("lw_22_read", ReadDataW, 32'd0);
    chk("lw_22_mis", {31'b0, MisalignW}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 3'b001, 5'd0, 32'h0000_0022, 32'h0000_1234);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0020, 32'h0);
    chk("lw_20_after_sh", ReadDataW, 32'h1234_F00D);

    step(1'b0, 1'b0, 1'b1, 3'b010, 5'd0, 32'h0000_0100, 32'h0000_0055);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_0000, 32'h0);
    chk("wrap_lw_0", ReadDataW, 32'h0000_0055);
    chk("wrap_alu", ALUResultW, 32'h0000_0000);

    step(1'b0, 1'b0, 1'b1, 3'b011, 5'd0, 32'h0000_0000, 32'h0000_0099);
    chk("bad_f3_store_mis", {31'b0, MisalignW}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'b111, 5'd8, 32'h0000_0000, 32'h0);
    chk("bad_f3_load", ReadDataW, 32'd0);
    chk("bad_f3_load_mis", {31'b0, MisalignW}, 32'd0);

    step(1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h0000_0000, 32'h1111_1111);
    chk("store_load_pre", ReadDataW, 32'h0000_0055);
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 32'h0000_0000, 32'h0);
    chk("store_load_post", ReadDataW, 32'h1111_1111);

    step(1'b1, 1'b0, 1'b0, 3'b010, 5'd5, 32'h0000_0042, 32'h0);
    chk("pass_regwrite", {31'b0, RegWriteW}, 32'd1);
    chk("pass_rd", {27'b0, RDW}, 32'd5);
    chk("pass_result", ResultW, 32'h0000_0042);

    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd12, 32'h0000_0010, 32'hBAD0_BAD0);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_regwrite", {31'b0, RegWriteW}, 32'd0);
    chk("mid_rst_rd", {27'b0, RDW}, 32'd0);
    chk("mid_rst_alu", ALUResultW, 32'd0);
    chk("mid_rst_result", ResultW, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_alu", ALUResultW, 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3'b010, 5'd1, 32'h0000_0010, 32'h0);
    chk("mid_rst_word_kept", ReadDataW, 32'h80AD_BEEF);
    chk("post_rst_rd", {27'b0, RDW}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
